// File: rtl/gpmc_pkg.sv
// Shared definitions for the GPMC host / internal memory arbiter.
// Contents: default address and data widths, the arbiter FSM state
// encoding, and the access source encoding.
package gpmc_pkg;

  localparam int unsigned ADDR_WIDTH_DEF = 16;
  localparam int unsigned DATA_WIDTH_DEF = 16;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    H_ISSUE = 3'd1,
    H_DONE  = 3'd2,
    I_ISSUE = 3'd3,
    I_DONE  = 3'd4
  } state_e;

  typedef enum logic {
    SRC_HOST = 1'b0,
    SRC_INT  = 1'b1
  } src_e;

endpackage

// File: rtl/gpmc_strobe_edge.sv
// Falling-edge detector for one active-low host strobe that is already
// synchronised to clk.
// Ports:
//   clk      - clock, rising edge
//   rst_n    - synchronous active-low reset
//   strobe_n - combined active-low strobe (e.g. cs | we)
//   fall     - one-cycle pulse in the cycle the strobe is first seen low
module gpmc_strobe_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic strobe_n,
  output logic fall
);

  logic prev_q, prev_d;
  // Detection is disarmed by reset until the strobe has been seen high, so
  // a strobe still held low across reset cannot produce an access.
  logic armed_q, armed_d;

  always_comb begin
    prev_d  = strobe_n;
    armed_d = armed_q | strobe_n;
  end

  assign fall = armed_q & prev_q & ~strobe_n;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values; blocking (=) here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev_q  <= 1'b1;
      armed_q <= 1'b0;
    end else begin
      prev_q  <= prev_d;
      armed_q <= armed_d;
    end
  end

endmodule

// File: rtl/gpmc_arbiter.sv
// Arbiter sharing one synchronous memory port between an asynchronous-style
// host bus (active-low cs/we/oe, pre-synchronised) and an internal
// valid/ready requester. Host has fixed priority over internal.
// Ports:
//   clk, rst_n                     - clock, synchronous active-low reset
//   host_cs/we/oe, host_addr/wdata - host strobes and request fields
//   host_rdata                     - result of the last host read
//   int_valid/we/addr/wdata        - internal request
//   int_ready                      - internal request accepted this cycle
//   int_rvalid, int_rdata          - internal read result (1-cycle pulse)
//   mem_en/we/addr/wdata, mem_rdata - memory port, read data 1 cycle after mem_en
// Configuration: define ARB_STARVE_GUARD_EN to add a starvation counter that
// forces an internal grant after STARVE_LIMIT host grants made while the
// internal requester was waiting.
module gpmc_arbiter
  import gpmc_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = ADDR_WIDTH_DEF,
  parameter int unsigned DATA_WIDTH   = DATA_WIDTH_DEF,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  host_cs,
  input  logic                  host_we,
  input  logic                  host_oe,
  input  logic [ADDR_WIDTH-1:0] host_addr,
  input  logic [DATA_WIDTH-1:0] host_wdata,
  output logic [DATA_WIDTH-1:0] host_rdata,
  input  logic                  int_valid,
  input  logic                  int_we,
  input  logic [ADDR_WIDTH-1:0] int_addr,
  input  logic [DATA_WIDTH-1:0] int_wdata,
  output logic                  int_ready,
  output logic                  int_rvalid,
  output logic [DATA_WIDTH-1:0] int_rdata,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  if (STARVE_LIMIT < 1) begin : g_bad_limit
    $error("gpmc_arbiter: STARVE_LIMIT must be at least 1");
  end

  // ---------------------------------------------------------------- host edges
  logic host_wr_n, host_rd_n;
  logic wr_fall, rd_fall, host_fall;

  assign host_wr_n = host_cs | host_we;
  assign host_rd_n = host_cs | host_oe;
  assign host_fall = wr_fall | rd_fall;

  gpmc_strobe_edge u_wr_edge (
    .clk      (clk),
    .rst_n    (rst_n),
    .strobe_n (host_wr_n),
    .fall     (wr_fall)
  );

  gpmc_strobe_edge u_rd_edge (
    .clk      (clk),
    .rst_n    (rst_n),
    .strobe_n (host_rd_n),
    .fall     (rd_fall)
  );

  // ------------------------------------------------------------- declarations
  state_e                state_q, state_d;
  logic                  host_pend_q, host_pend_d;
  logic [ADDR_WIDTH-1:0] hl_addr_q, hl_addr_d;
  logic [DATA_WIDTH-1:0] hl_wdata_q, hl_wdata_d;
  logic                  hl_we_q, hl_we_d;
  logic                  acc_we_q, acc_we_d;      // type of the access in flight
  logic [DATA_WIDTH-1:0] host_rdata_q, host_rdata_d;
  logic [DATA_WIDTH-1:0] int_rdata_q, int_rdata_d;
  logic                  int_rvalid_q, int_rvalid_d;
  logic                  force_int;
  src_e                  issue_src;

  // ------------------------------------------------------- starvation guard
`ifdef ARB_STARVE_GUARD_EN
  localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;

  // Saturates at the limit; only the IDLE grant decision moves it.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (state_q == IDLE && state_d == I_ISSUE) begin
      starve_cnt_d = '0;
    end else if (state_q == IDLE && state_d == H_ISSUE && int_valid &&
                 starve_cnt_q != LIMIT_C) begin
      starve_cnt_d = starve_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) starve_cnt_q <= '0;
    else        starve_cnt_q <= starve_cnt_d;
  end

  assign force_int = int_valid && (starve_cnt_q == LIMIT_C);
`else
  assign force_int = 1'b0;
`endif

  // ------------------------------------------------------- FSM: state register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // ----------------------------------------------------- FSM: next-state logic
  // An internal request is held off in a cycle where a host edge is being
  // detected, so a host edge coincident with int_valid wins even though its
  // pending flag only appears one cycle later.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (force_int)                   state_d = I_ISSUE;
        else if (host_pend_q)            state_d = H_ISSUE;
        else if (int_valid && !host_fall) state_d = I_ISSUE;
      end
      H_ISSUE: state_d = H_DONE;
      I_ISSUE: state_d = I_DONE;
      H_DONE,
      I_DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // --------------------------------------------------------- FSM: outputs
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    int_ready = 1'b0;
    issue_src = SRC_HOST;
    unique case (state_q)
      H_ISSUE: begin
        mem_en    = 1'b1;
        issue_src = SRC_HOST;
      end
      I_ISSUE: begin
        mem_en    = 1'b1;
        int_ready = 1'b1;
        issue_src = SRC_INT;
      end
      default: ;
    endcase
    if (mem_en) begin
      unique case (issue_src)
        SRC_HOST: begin
          mem_we    = hl_we_q;
          mem_addr  = hl_addr_q;
          mem_wdata = hl_wdata_q;
        end
        SRC_INT: begin
          mem_we    = int_we;
          mem_addr  = int_addr;
          mem_wdata = int_wdata;
        end
        default: ;
      endcase
    end
  end

  // ------------------------------------------------ host latch and read data
  // A new host edge always reloads the latch (dropping any older request) and
  // takes precedence over the clear in H_ISSUE; the issue cycle itself still
  // drives the previously latched values.
  always_comb begin
    host_pend_d  = host_pend_q;
    hl_addr_d    = hl_addr_q;
    hl_wdata_d   = hl_wdata_q;
    hl_we_d      = hl_we_q;
    acc_we_d     = acc_we_q;
    host_rdata_d = host_rdata_q;
    int_rdata_d  = int_rdata_q;
    int_rvalid_d = 1'b0;

    if (host_fall) begin
      host_pend_d = 1'b1;
      hl_addr_d   = host_addr;
      hl_wdata_d  = host_wdata;
      hl_we_d     = wr_fall;
    end else if (state_q == H_ISSUE) begin
      host_pend_d = 1'b0;
    end

    if (mem_en) acc_we_d = mem_we;

    // mem_rdata is valid during the done cycle; results register at its end.
    if (state_q == H_DONE && !acc_we_q) host_rdata_d = mem_rdata;
    if (state_q == I_DONE && !acc_we_q) begin
      int_rdata_d  = mem_rdata;
      int_rvalid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      host_pend_q  <= 1'b0;
      hl_addr_q    <= '0;
      hl_wdata_q   <= '0;
      hl_we_q      <= 1'b0;
      acc_we_q     <= 1'b0;
      host_rdata_q <= '0;
      int_rdata_q  <= '0;
      int_rvalid_q <= 1'b0;
    end else begin
      host_pend_q  <= host_pend_d;
      hl_addr_q    <= hl_addr_d;
      hl_wdata_q   <= hl_wdata_d;
      hl_we_q      <= hl_we_d;
      acc_we_q     <= acc_we_d;
      host_rdata_q <= host_rdata_d;
      int_rdata_q  <= int_rdata_d;
      int_rvalid_q <= int_rvalid_d;
    end
  end

  assign host_rdata = host_rdata_q;
  assign int_rdata  = int_rdata_q;
  assign int_rvalid = int_rvalid_q;

endmodule

// File: tb/tb_gpmc_arbiter.sv
// Self-checking bench for gpmc_arbiter: a table of single accesses from
// either source, plus hand-written sequences for held strobes, simultaneous
// requests, starvation behaviour and reset in the middle of an access.
module tb_gpmc_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        host_cs, host_we, host_oe;
  logic [15:0] host_addr, host_wdata, host_rdata;
  logic        int_valid, int_we, int_ready, int_rvalid;
  logic [15:0] int_addr, int_wdata, int_rdata;
  logic        mem_en, mem_we;
  logic [15:0] mem_addr, mem_wdata;
  logic [15:0] mem_rdata = '0;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  gpmc_arbiter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .host_cs    (host_cs),
    .host_we    (host_we),
    .host_oe    (host_oe),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
    .host_rdata (host_rdata),
    .int_valid  (int_valid),
    .int_we     (int_we),
    .int_addr   (int_addr),
    .int_wdata  (int_wdata),
    .int_ready  (int_ready),
    .int_rvalid (int_rvalid),
    .int_rdata  (int_rdata),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  // Memory model: synchronous RAM, read data valid one cycle after mem_en.
  logic [15:0] mem [256];
  initial for (int i = 0; i < 256; i++) mem[i] = '0;
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
      mem_rdata <= mem[mem_addr[7:0]];
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic        is_host;
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp_rdata;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits up to 10 cycles for mem_en; lat = cycles waited, -1 on timeout.
  task automatic wait_mem_en(output int lat);
    lat = -1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (mem_en === 1'b1) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic do_host(input logic we, input logic [15:0] addr,
                         input logic [15:0] wdata, input logic [15:0] exp_rd);
    int lat;
    host_addr  = addr;
    host_wdata = wdata;
    host_cs    = 1'b0;
    if (we) host_we = 1'b0;
    else    host_oe = 1'b0;
    wait_mem_en(lat);
    check("host_edge_to_mem_en", lat, 2);
    check("host_int_ready_low", int_ready, 0);
    check("host_mem_we", mem_we, we);
    check("host_mem_addr", mem_addr, addr);
    if (we) check("host_mem_wdata", mem_wdata, wdata);
    host_cs = 1'b1;
    host_we = 1'b1;
    host_oe = 1'b1;
    if (!we) begin
      tick();
      tick();
      check("host_rdata", host_rdata, exp_rd);
      repeat (3) tick();
      check("host_rdata_hold", host_rdata, exp_rd);
    end else begin
      tick();
      tick();
    end
  endtask

  task automatic do_int(input logic we, input logic [15:0] addr,
                        input logic [15:0] wdata, input logic [15:0] exp_rd);
    int lat;
    int_valid = 1'b1;
    int_we    = we;
    int_addr  = addr;
    int_wdata = wdata;
    wait_mem_en(lat);
    check("int_valid_to_mem_en", lat, 1);
    check("int_ready", int_ready, 1);
    check("int_mem_we", mem_we, we);
    check("int_mem_addr", mem_addr, addr);
    if (we) check("int_mem_wdata", mem_wdata, wdata);
    int_valid = 1'b0;
    tick();
    check("int_rvalid_done_cycle", int_rvalid, 0);
    tick();
    check("int_rvalid_result", int_rvalid, !we);
    if (!we) check("int_rdata", int_rdata, exp_rd);
    tick();
    check("int_rvalid_single", int_rvalid, 0);
    tick();
  endtask

  vec_t vecs[11];

  initial begin
    int cnt, lat, host_cyc, int_cyc, host_grants, grants_before;
    logic got_we, served;
    logic [15:0] got_addr, got_wdata;

    vecs[0]  = '{1'b1, 1'b0, 16'h0010, 16'h0000, 16'hBEEF};
    vecs[1]  = '{1'b0, 1'b1, 16'h0020, 16'h1234, 16'h0000};
    vecs[2]  = '{1'b0, 1'b0, 16'h0020, 16'h0000, 16'h1234};
    vecs[3]  = '{1'b1, 1'b0, 16'h0020, 16'h0000, 16'h1234};
    vecs[4]  = '{1'b0, 1'b0, 16'h0010, 16'h0000, 16'hBEEF};
    vecs[5]  = '{1'b1, 1'b1, 16'h0030, 16'hA5A5, 16'h0000};
    vecs[6]  = '{1'b0, 1'b0, 16'h0030, 16'h0000, 16'hA5A5};
    vecs[7]  = '{1'b1, 1'b1, 16'h00FF, 16'hFFFF, 16'h0000};
    vecs[8]  = '{1'b1, 1'b0, 16'h00FF, 16'h0000, 16'hFFFF};
    vecs[9]  = '{1'b0, 1'b1, 16'h0040, 16'h0000, 16'h0000};
    vecs[10] = '{1'b1, 1'b0, 16'h0040, 16'h0000, 16'h0000};

    rst_n = 1'b0;
    host_cs = 1'b1; host_we = 1'b1; host_oe = 1'b1;
    host_addr = '0; host_wdata = '0;
    int_valid = 1'b0; int_we = 1'b0; int_addr = '0; int_wdata = '0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // Reset state.
    check("rst_mem_en", mem_en, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_int_ready", int_ready, 0);
    check("rst_int_rvalid", int_rvalid, 0);
    check("rst_host_rdata", host_rdata, 0);
    check("rst_int_rdata", int_rdata, 0);

    // Host write with strobe held 10+ cycles: exactly one access.
    host_addr = 16'h0010; host_wdata = 16'hBEEF;
    host_cs = 1'b0; host_we = 1'b0;
    cnt = 0; got_we = 1'b0; got_addr = '0; got_wdata = '0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (mem_en === 1'b1) begin
        cnt++;
        got_we = mem_we; got_addr = mem_addr; got_wdata = mem_wdata;
      end
    end
    check("held_write_access_count", cnt, 1);
    check("held_write_mem_we", got_we, 1);
    check("held_write_mem_addr", got_addr, 16'h0010);
    check("held_write_mem_wdata", got_wdata, 16'hBEEF);
    host_cs = 1'b1; host_we = 1'b1;
    repeat (2) tick();

    // Table of single accesses.
    for (int v = 0; v < 11; v++) begin
      if (vecs[v].is_host) do_host(vecs[v].we, vecs[v].addr, vecs[v].wdata, vecs[v].exp_rdata);
      else                 do_int(vecs[v].we, vecs[v].addr, vecs[v].wdata, vecs[v].exp_rdata);
    end

    // Simultaneous host write and internal read: host first. The internal
    // grant takes the first arbitration slot after the host done cycle.
    host_addr = 16'h0040; host_wdata = 16'h5555;
    host_cs = 1'b0; host_we = 1'b0;
    int_valid = 1'b1; int_we = 1'b0; int_addr = 16'h0010;
    host_cyc = -1; int_cyc = -1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (mem_en === 1'b1 && int_ready === 1'b0 && host_cyc < 0) begin
        host_cyc = i;
        got_addr = mem_addr;
        host_cs = 1'b1; host_we = 1'b1;
      end
      if (int_ready === 1'b1 && int_cyc < 0) begin
        int_cyc = i;
        int_valid = 1'b0;
      end
    end
    check("simul_host_cycle", host_cyc, 2);
    check("simul_host_addr", got_addr, 16'h0040);
    check("simul_int_cycle", int_cyc, 5);
    check("simul_int_rdata", int_rdata, 16'hBEEF);

    // Starvation: host re-strobes during every host issue cycle so host_pend
    // stays set, while the internal request is held valid.
    host_addr = 16'h0050; host_wdata = 16'h7777;
    host_cs = 1'b0; host_we = 1'b0;
    int_valid = 1'b1; int_we = 1'b0; int_addr = 16'h0020;
    host_grants = 0; grants_before = -1; served = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (int_ready === 1'b1) begin
        grants_before = host_grants;
        served = 1'b1;
        int_valid = 1'b0;
        host_cs = 1'b1; host_we = 1'b1;
        break;
      end
      if (mem_en === 1'b1) begin
        host_grants++;
        host_cs = 1'b0; host_we = 1'b0;
      end else begin
        host_cs = 1'b1; host_we = 1'b1;
      end
    end
`ifdef ARB_STARVE_GUARD_EN
    check("starve_int_granted", served, 1);
    check("starve_host_grants_before_int", grants_before, 4);
`else
    check("starve_int_never_granted", served, 0);
    check("starve_host_grants_ge10", host_grants >= 10, 1);
`endif
    host_cs = 1'b1; host_we = 1'b1;
    if (!served) begin
      for (int i = 0; i < 12; i++) begin
        tick();
        if (int_ready === 1'b1) begin
          served = 1'b1;
          int_valid = 1'b0;
          break;
        end
      end
    end
    check("starve_int_served_after_host", served, 1);
    repeat (6) tick();

    // Reset while the internal access is in its issue cycle, host read strobe
    // held low throughout.
    host_addr = 16'h0010; host_cs = 1'b0; host_oe = 1'b0;
    int_valid = 1'b1; int_we = 1'b0; int_addr = 16'h0020;
    served = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (int_ready === 1'b1) begin
        served = 1'b1;
        break;
      end
    end
    check("rst_mid_reached_int_issue", served, 1);
    rst_n = 1'b0;
    int_valid = 1'b0;
    tick();
    check("rst_mid_mem_en", mem_en, 0);
    check("rst_mid_mem_we", mem_we, 0);
    check("rst_mid_mem_addr", mem_addr, 0);
    check("rst_mid_mem_wdata", mem_wdata, 0);
    check("rst_mid_int_ready", int_ready, 0);
    check("rst_mid_int_rvalid", int_rvalid, 0);
    check("rst_mid_host_rdata", host_rdata, 0);
    check("rst_mid_int_rdata", int_rdata, 0);
    tick();
    rst_n = 1'b1;
    cnt = 0; lat = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (mem_en === 1'b1) cnt++;
      if (int_rvalid === 1'b1) lat++;
    end
    check("rst_held_strobe_no_access", cnt, 0);
    check("rst_no_int_rvalid", lat, 0);
    host_cs = 1'b1; host_oe = 1'b1;
    tick();
    host_cs = 1'b0; host_oe = 1'b0;
    wait_mem_en(lat);
    check("rst_restrobe_latency", lat, 2);
    check("rst_restrobe_mem_addr", mem_addr, 16'h0010);
    check("rst_restrobe_mem_we", mem_we, 0);
    host_cs = 1'b1; host_oe = 1'b1;
    tick();
    tick();
    check("rst_restrobe_host_rdata", host_rdata, 16'hBEEF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
